morse_tx: RTL and testbench

MORSE_TX -- requirements
Module: morse_tx

---
 rtl/morse_tx_if.sv | 24 ++
 rtl/morse_tx.sv | 165 ++++++++++++++++
 tb/tb_morse_tx.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_tx_if.sv
// Control and output bundle for the Morse serialiser; master drives the request side.
interface morse_tx_if #(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5
);
    logic             start;
    logic             abort;
    logic             repeat_en;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic             led_out;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, repeat_en, pat, len,
        input  led_out, busy, done
    );

    modport slave (
        input  start, abort, repeat_en, pat, len,
        output led_out, busy, done
    );
endinterface

// File: rtl/morse_tx.sv
// Morse serialiser: captured pattern goes out LSB first, one element per DIV_MAX+1 cycles, optional looping.
// First element appears 1 cycle after start; no backpressure, start is ignored while busy.
module morse_tx #(
    parameter int PAT_W     = 16,
    parameter int LEN_W     = 5,
    parameter int DIV_MAX   = 24999999,
    parameter int GAP_TICKS = 7
) (
    input  logic      clock,
    input  logic      reset_n,
    morse_tx_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam int DIV_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP_TICKS);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [1:0]       state_q,   state_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [PAT_W-1:0] shreg_q,   shreg_d;
    logic [PAT_W-1:0] pat_cap_q, pat_cap_d;
    logic [LEN_W-1:0] len_cap_q, len_cap_d;
    logic [LEN_W-1:0] cnt_q,     cnt_d;
    logic [GAP_W-1:0] gap_q,     gap_d;
    logic             led_q,     led_d;
    logic             done_q,    done_d;

    logic             tick;
    logic [LEN_W-1:0] eff_len;
    logic [PAT_W-1:0] shifted;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        shreg_d   = shreg_q;
        pat_cap_d = pat_cap_q;
        len_cap_d = len_cap_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        led_d     = led_q;
        done_d    = 1'b0;

        tick    = (div_q == DIV_TC);
        eff_len = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
        shifted = shreg_q >> 1;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (eff_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        pat_cap_d = bus.pat;
                        len_cap_d = eff_len;
                        shreg_d   = bus.pat;
                        cnt_d     = eff_len;
                        div_d     = '0;
                        led_d     = bus.pat[0];
                        state_d   = SEND;
                    end
                end
            end

            SEND: begin
                div_d = tick ? '0 : div_q + DIV_ONE;
                if (tick) begin
                    if (cnt_q == LEN_ONE) begin
                        // repeat_en only matters here, at the pattern boundary
                        if (!bus.repeat_en) begin
                            state_d = IDLE;
                            led_d   = 1'b0;
                            done_d  = 1'b1;
                            shreg_d = '0;
                            cnt_d   = '0;
                        end else if (GAP_TICKS == 0) begin
                            shreg_d = pat_cap_q;
                            cnt_d   = len_cap_q;
                            led_d   = pat_cap_q[0];
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_LD;
                            led_d   = 1'b0;
                            shreg_d = '0;
                            cnt_d   = '0;
                        end
                    end else begin
                        shreg_d = shifted;
                        led_d   = shifted[0];
                        cnt_d   = cnt_q - LEN_ONE;
                    end
                end
            end

            GAP: begin
                div_d = tick ? '0 : div_q + DIV_ONE;
                if (tick) begin
                    if (gap_q == GAP_ONE) begin
                        state_d = SEND;
                        gap_d   = '0;
                        shreg_d = pat_cap_q;
                        cnt_d   = len_cap_q;
                        led_d   = pat_cap_q[0];
                    end else begin
                        gap_d = gap_q - GAP_ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                led_d   = 1'b0;
            end
        endcase

        // abort wins over tick, reload and completion
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            div_d   = '0;
            shreg_d = '0;
            cnt_d   = '0;
            gap_d   = '0;
            led_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            shreg_q   <= '0;
            pat_cap_q <= '0;
            len_cap_q <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            led_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            shreg_q   <= shreg_d;
            pat_cap_q <= pat_cap_d;
            len_cap_q <= len_cap_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            led_q     <= led_d;
            done_q    <= done_d;
        end
    end

    assign bus.led_out = led_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_morse_tx.sv
// Three morse_tx instances (different divider/gap settings) share one stimulus stream and are
// compared every cycle against a timeline model: element index = elapsed cycles / period.
module tb_morse_tx;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic        repeat_en = 1'b0;
    logic [15:0] pat       = '0;
    logic [4:0]  len       = '0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2:0] obs   [3];   // {led_out, busy, done}
    logic [2:0] exp_o [3];

    always #5 clock = ~clock;

    function automatic int dv(input int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    function automatic int gv(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 7;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        morse_tx_if bus_i ();
        assign bus_i.start     = start;
        assign bus_i.abort     = abort;
        assign bus_i.repeat_en = repeat_en;
        assign bus_i.pat       = pat;
        assign bus_i.len       = len;
        assign obs[k]          = {bus_i.led_out, bus_i.busy, bus_i.done};

        morse_tx #(
            .PAT_W    (16),
            .LEN_W    (5),
            .DIV_MAX  ((k == 0) ? 0 : (k == 1) ? 1 : 3),
            .GAP_TICKS((k == 0) ? 0 : (k == 1) ? 2 : 7)
        ) u_dut (
            .clock  (clock),
            .reset_n(reset_n),
            .bus    (bus_i)
        );
    end

    // Reference: active flag, elapsed cycles since the current pattern began, captured copy.
    typedef struct packed {
        logic        act;
        logic        dn;
        logic [15:0] p;
        logic [5:0]  l;
        logic [7:0]  e;
    } mst_t;

    mst_t m_st [3];

    function automatic mst_t m_next(input mst_t s, input int per, input int g,
                                    input logic st, input logic ab, input logic rp,
                                    input logic [15:0] pt, input logic [4:0] ln_in);
        mst_t n;
        int   ln;
        int   el;
        n    = s;
        n.dn = 1'b0;
        if (!s.act) begin
            if (st && !ab) begin
                ln = (ln_in > 5'd16) ? 16 : int'(ln_in);
                if (ln == 0) begin
                    n.dn = 1'b1;
                end else begin
                    n.act = 1'b1;
                    n.e   = '0;
                    n.p   = pt;
                    n.l   = 6'(ln);
                end
            end
        end else if (ab) begin
            n.act = 1'b0;
        end else begin
            el  = int'(s.l) * per;
            n.e = s.e + 8'd1;
            if (int'(n.e) == el) begin
                if (!rp) begin
                    n.act = 1'b0;
                    n.dn  = 1'b1;
                end else if (g == 0) begin
                    n.e = '0;
                end
            end else if (int'(n.e) == el + g * per) begin
                n.e = '0;
            end
        end
        return n;
    endfunction

    function automatic logic [2:0] m_out(input mst_t s, input int per);
        int   idx;
        logic led;
        led = 1'b0;
        if (s.act) begin
            idx = int'(s.e) / per;
            if (idx < int'(s.l)) led = s.p[idx];
        end
        return {led, s.act, s.dn};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) m_st[k] <= '0;
            else          m_st[k] <= m_next(m_st[k], dv(k) + 1, gv(k), start, abort, repeat_en, pat, len);
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) exp_o[k] = m_out(m_st[k], dv(k) + 1);
    end

    task automatic drain();
        start     = 1'b0;
        repeat_en = 1'b0;
        abort     = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (obs[k] !== 3'b000) begin
                n_fail++;
                $display("FAIL reset dut%0d {led,busy,done} got %b expected 000", k, obs[k]);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_shot();
        int busy_cnt = 0, hi_cnt = 0, done_cnt = 0;
        pat = 16'b0000000000010101; len = 5'd5; repeat_en = 1'b0; start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL single dut%0d t=%0t got %b expected %b", k, $time, obs[k], exp_o[k]);
                end
            end
            busy_cnt += int'(obs[2][1]);
            hi_cnt   += int'(obs[2][2]);
            done_cnt += int'(obs[2][0]);
        end
        n_assert++;
        if (busy_cnt !== 20) begin n_fail++; $display("FAIL single_busy_cycles got %0d expected 20", busy_cnt); end
        n_assert++;
        if (hi_cnt !== 12) begin n_fail++; $display("FAIL single_high_cycles got %0d expected 12", hi_cnt); end
        n_assert++;
        if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done_pulses got %0d expected 1", done_cnt); end
    endtask

    task automatic test_repeat();
        int hi_cnt = 0;
        int done_cnt [3] = '{0, 0, 0};
        pat = 16'h0007; len = 5'd3; repeat_en = 1'b1; start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL repeat dut%0d t=%0t got %b expected %b", k, $time, obs[k], exp_o[k]);
                end
                done_cnt[k] += int'(obs[k][0]);
            end
            if (c <= 20) hi_cnt += int'(obs[1][2]);
        end
        n_assert++;
        if (hi_cnt !== 12) begin n_fail++; $display("FAIL repeat_high_cycles got %0d expected 12", hi_cnt); end
        n_assert++;
        if (done_cnt[1] !== 0) begin n_fail++; $display("FAIL repeat_no_done got %0d expected 0", done_cnt[1]); end
        repeat_en = 1'b0;
        done_cnt  = '{0, 0, 0};
        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL repeat_stop dut%0d t=%0t got %b expected %b", k, $time, obs[k], exp_o[k]);
                end
                done_cnt[k] += int'(obs[k][0]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (done_cnt[k] !== 1 || obs[k][1] !== 1'b0) begin
                n_fail++;
                $display("FAIL repeat_stop_done dut%0d done_pulses %0d busy %b expected 1 and 0", k, done_cnt[k], obs[k][1]);
            end
        end
    endtask

    task automatic test_abort();
        int done_cnt [3] = '{0, 0, 0};
        pat = 16'($urandom); len = 5'd14; repeat_en = 1'b0; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL abort dut%0d t=%0t got %b expected %b", k, $time, obs[k], exp_o[k]);
                end
                if (c == 10) begin
                    n_assert++;
                    if (obs[k] !== 3'b000) begin
                        n_fail++;
                        $display("FAIL abort_idle dut%0d got %b expected 000", k, obs[k]);
                    end
                end
            end
            abort = (c == 9);
        end
        abort = 1'b1; start = 1'b1; pat = 16'hFFFF; len = 5'd4;
        @(negedge clock);
        abort = 1'b0; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (obs[k] !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_and_start dut%0d got %b expected 000", k, obs[k]);
            end
        end
        pat = 16'($urandom); len = 5'd14; start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL abort_restart dut%0d t=%0t got %b expected %b", k, $time, obs[k], exp_o[k]);
                end
                done_cnt[k] += int'(obs[k][0]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (done_cnt[k] !== 1) begin
                n_fail++;
                $display("FAIL abort_restart_done dut%0d got %0d expected 1", k, done_cnt[k]);
            end
        end
    endtask

    task automatic test_edge();
        int busy0 = 0;
        pat = 16'($urandom); len = 5'd0; start = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== ((c == 1) ? 3'b001 : 3'b000)) begin
                    n_fail++;
                    $display("FAIL len0 dut%0d cycle %0d got %b expected %b", k, c, obs[k], (c == 1) ? 3'b001 : 3'b000);
                end
            end
        end
        pat = 16'($urandom); len = 5'd31; start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL len31 dut%0d t=%0t got %b expected %b", k, $time, obs[k], exp_o[k]);
                end
            end
            busy0 += int'(obs[0][1]);
            pat = 16'($urandom);
            len = 5'($urandom_range(1, 31));
            start = (c == 3 || c == 7 || c == 11);
        end
        n_assert++;
        if (busy0 !== 16) begin n_fail++; $display("FAIL len31_elements got %0d expected 16", busy0); end
    endtask

    task automatic test_full_length();
        int hi_cnt = 0, first_hi = -1, last_hi = -1, done_at = -1;
        pat = 16'hFFFF; len = 5'd16; repeat_en = 1'b0; start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL full dut%0d t=%0t got %b expected %b", k, $time, obs[k], exp_o[k]);
                end
            end
            if (obs[0][2]) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = c;
                last_hi = c;
            end
            if (obs[0][0] && done_at < 0) done_at = c;
        end
        n_assert++;
        if (hi_cnt !== 16 || first_hi !== 1 || last_hi !== 16) begin
            n_fail++;
            $display("FAIL full_high got %0d cycles %0d..%0d expected 16 cycles 1..16", hi_cnt, first_hi, last_hi);
        end
        n_assert++;
        if (done_at !== 17) begin n_fail++; $display("FAIL full_done_cycle got %0d expected 17", done_at); end
    endtask

    task automatic test_async_reset();
        pat = 16'($urandom) | 16'h0001; len = 5'd10; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL areset_pre dut%0d t=%0t got %b expected %b", k, $time, obs[k], exp_o[k]);
                end
            end
        end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (obs[k] !== 3'b000) begin
                n_fail++;
                $display("FAIL areset_now dut%0d got %b expected 000", k, obs[k]);
            end
        end
        @(negedge clock);
        reset_n = 1'b1; pat = 16'($urandom); len = 5'd3; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== exp_o[k] || (c == 1 && obs[k][1] !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL areset_post dut%0d cycle %0d got %b expected %b", k, c, obs[k], exp_o[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 1; c <= 400; c++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) repeat_en = ~repeat_en;
            pat = 16'($urandom);
            len = 5'($urandom_range(0, 31));
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL random dut%0d t=%0t got %b expected %b", k, $time, obs[k], exp_o[k]);
                end
                n_assert++;
                if (obs[k][1] && obs[k][0]) begin
                    n_fail++;
                    $display("FAIL random_done_busy dut%0d busy %b done %b expected not both 1", k, obs[k][1], obs[k][0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        drain();
        test_repeat();
        drain();
        test_abort();
        drain();
        test_edge();
        drain();
        test_full_length();
        drain();
        test_async_reset();
        drain();
        test_random();
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
